// File: rtl/sprite_motion_ctl.sv
// sprite_motion_ctl: moves the player sprite once per frame (jump/fall physics
// and clamped left/right steps) and overlays the sprite ROM onto the incoming
// background pixel through a two-stage pipeline with colour-key transparency.
module sprite_motion_ctl #(
   parameter int          X_INIT      = 350,
   parameter int          Y_FLOOR     = 370,
   parameter int          Y_TOP       = 220,
   parameter int          X_MIN       = 0,
   parameter int          X_MAX       = 960,
   parameter int          JUMP_VEL    = 12,
   parameter int          GRAVITY     = 1,
   parameter int          VMAX_FALL   = 12,
   parameter int          H_STEP      = 2,
   parameter int          SPRITE_W    = 64,
   parameter int          SPRITE_H    = 64,
   parameter int          ADDR_W      = 12,
   parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              v_tick,
   input  logic              jump_btn,
   input  logic              left_btn,
   input  logic              right_btn,
   input  logic [11:0]       hcount,
   input  logic [11:0]       vcount,
   input  logic [11:0]       rgb_in,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [11:0]       rgb_out,
   output logic [11:0]       xpos,
   output logic [11:0]       ypos,
   output logic              airborne
);

   typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

   localparam logic signed [12:0] Y_TOP_S   = 13'(Y_TOP);
   localparam logic signed [12:0] Y_FLOOR_S = 13'(Y_FLOOR);
   localparam logic signed [12:0] X_MIN_S   = 13'(X_MIN);
   localparam logic signed [12:0] X_MAX_S   = 13'(X_MAX);
   localparam logic signed [12:0] H_STEP_S  = 13'(H_STEP);
   localparam logic signed [8:0]  GRAV_S    = 9'(GRAVITY);
   localparam logic signed [8:0]  VMAX_S    = 9'(VMAX_FALL);
   localparam logic signed [7:0]  JUMP_S    = 8'(JUMP_VEL);

   state_t             state_q, state_d;
   logic signed [7:0]  vel_q, vel_d;
   logic [11:0]        x_q, x_d, y_q, y_d;
   logic               armed_q, armed_d;
   logic               air_q;
   logic               v_tick_q;
   logic               frameTick;
   logic               launch;
   logic signed [12:0] x13, y13, vel13, yUp, yDown, xLeft, xRight;
   logic signed [8:0]  velRise, velFall;

   logic               inBox;
   logic [11:0]        dx, dy;
   logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
   logic               inBox_q;
   logic [11:0]        rgbIn_q, rgbOut_q;

   assign frameTick = v_tick & ~v_tick_q;
   assign launch    = (state_q == GROUND) && jump_btn && armed_q;

   // Widen position and speed by one bit so step/clamp arithmetic cannot wrap
   assign x13     = $signed({1'b0, x_q});
   assign y13     = $signed({1'b0, y_q});
   assign vel13   = $signed({{5{vel_q[7]}}, vel_q});
   assign yUp     = y13 - vel13;
   assign yDown   = y13 + vel13;
   assign xLeft   = x13 - H_STEP_S;
   assign xRight  = x13 + H_STEP_S;
   assign velRise = $signed({vel_q[7], vel_q}) - GRAV_S;
   assign velFall = $signed({vel_q[7], vel_q}) + GRAV_S;

   // Next motion state for the coming frame update: vertical physics, jump arming, horizontal clamp
   always_comb begin
      state_d = state_q;
      vel_d   = vel_q;
      y_d     = y_q;
      x_d     = x_q;
      armed_d = armed_q;

      case (state_q)
         GROUND: begin
            if (launch) begin
               state_d = RISE;
               vel_d   = JUMP_S;
            end
         end
         RISE: begin
            if (yUp <= Y_TOP_S) begin
               y_d     = 12'(Y_TOP);
               vel_d   = 8'sd0;
               state_d = FALL;
            end else begin
               y_d = yUp[11:0];
               if (velRise <= 9'sd0) begin
                  vel_d   = 8'sd0;
                  state_d = FALL;
               end else begin
                  vel_d = velRise[7:0];
               end
            end
         end
         FALL: begin
            if (yDown >= Y_FLOOR_S) begin
               y_d     = 12'(Y_FLOOR);
               vel_d   = 8'sd0;
               state_d = GROUND;
            end else begin
               y_d   = yDown[11:0];
               vel_d = (velFall > VMAX_S) ? VMAX_S[7:0] : velFall[7:0];
            end
         end
         default: begin
            state_d = GROUND;
            vel_d   = 8'sd0;
         end
      endcase

      if (!jump_btn) begin
         armed_d = 1'b1;
      end else if (launch) begin
         armed_d = 1'b0;
      end

      if (left_btn && !right_btn) begin
         x_d = (xLeft < X_MIN_S) ? 12'(X_MIN) : xLeft[11:0];
      end else if (right_btn && !left_btn) begin
         x_d = (xRight > X_MAX_S) ? 12'(X_MAX) : xRight[11:0];
      end
   end

   // Motion registers: tick edge detect every cycle, everything else only on a frame update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_tick_q <= 1'b0;
         state_q  <= GROUND;
         vel_q    <= 8'sd0;
         x_q      <= 12'(X_INIT);
         y_q      <= 12'(Y_FLOOR);
         armed_q  <= 1'b1;
         air_q    <= 1'b0;
      end else begin
         v_tick_q <= v_tick;
         if (frameTick) begin
            state_q <= state_d;
            vel_q   <= vel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            armed_q <= armed_d;
            air_q   <= (state_d != GROUND);
         end
      end
   end

   // Sprite hit test and ROM address from the live position registers
   assign inBox = (hcount >= x_q) && ({1'b0, hcount} < ({1'b0, x_q} + 13'(SPRITE_W))) &&
                  (vcount >= y_q) && ({1'b0, vcount} < ({1'b0, y_q} + 13'(SPRITE_H)));
   assign dx = hcount - x_q;
   assign dy = vcount - y_q;
   assign rom_addr_d = inBox ? (ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx)) : '0;

   // Pixel pipeline: stage 1 issues the ROM address, stage 2 keys ROM data over the background
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rom_addr_q <= '0;
         inBox_q    <= 1'b0;
         rgbIn_q    <= 12'h000;
         rgbOut_q   <= 12'h000;
      end else begin
         rom_addr_q <= rom_addr_d;
         inBox_q    <= inBox;
         rgbIn_q    <= rgb_in;
         rgbOut_q   <= (inBox_q && (rom_data != TRANSPARENT)) ? rom_data : rgbIn_q;
      end
   end

   assign rom_addr = rom_addr_q;
   assign rgb_out  = rgbOut_q;
   assign xpos     = x_q;
   assign ypos     = y_q;
   assign airborne = air_q;

endmodule
